prbs9_sync_checker: RTL
=======================

// Module: prbs9_sync_checker
// PURPOSE
//  Receive-side PRBS9 checker: the reader for the PRBS9 transmit generator.
//  Sits after the receiver's detector, sampling i_bit on each i_valid strobe from the symbol-rate FSM.
//  Self-synchronises to the incoming sequence with no phase search, then counts compared bits and errors.
//  Detects loss of lock and re-acquires.
// PARAMETERS
//  CNT_W     32  width of o_bit_count / o_err_count
//  LOCK_CNT  16  consecutive correct predictions needed in VERIFY to declare lock (1..511)
//  WIN_LEN   128 bits per loss-of-lock evaluation window in LOCK (>=2)
//  ERR_THR   16  errors within one window that declare loss of lock (1..WIN_LEN)
// PORTS
//  clk          in   1      system clock, all logic rising-edge
//  rst          in   1      asynchronous reset, active-low
//  i_enable     in   1      0: hold all state/outputs frozen; 1: run
//  i_valid      in   1      one-cycle strobe, i_bit is a new symbol decision
//  i_bit        in   1      detected bit from receiver
//  o_locked     out  1      1 while FSM in LOCK
//  o_err        out  1      one-cycle pulse, compared bit mismatched (LOCK only)
//  o_lock_lost  out  1      one-cycle pulse on LOCK->SEED transition
//  o_bit_count  out  CNT_W  bits compared while locked
//  o_err_count  out  CNT_W  mismatches while locked
// BEHAVIOUR
//  - Reset (rst=0, async): state=SEED, sreg=0, all counters 0, all outputs 0.
//  - Sequence: b[n] = b[n-9] ^ b[n-5]; sreg[0] newest bit, pred = sreg[8]^sreg[4].
//  - Only cycles with i_enable=1 && i_valid=1 ("sample") advance anything; o_err/o_lock_lost are 0 otherwise.
//  - SEED: shift i_bit into sreg; fill counter 0..9. After 9th sample -> VERIFY (match count cleared).
//    If sreg==0 after fill (illegal all-zero state), stay SEED with fill counter reset.
//  - VERIFY: compare i_bit to pred; always shift i_bit into sreg.
//    Match: match count +1; reaching LOCK_CNT -> LOCK.
//    Mismatch: -> SEED with fill counter reset.
//  - LOCK: sreg free-runs on its own pred (shift in pred, not i_bit), so errors do not propagate.
//    Each sample: bit count +1; if i_bit!=pred, err count +1 and o_err=1 next cycle.
//    Window: counts WIN_LEN samples with window error count. Window error count reaching ERR_THR ->
//    o_lock_lost=1, state SEED, fill=0; o_bit_count/o_err_count retain values. Window end clears window counts.
//  - Latency: o_err, o_locked, o_lock_lost, and counters update on the clock edge that registers the sample (1 cycle).
//  - Counters are global; cleared only by rst. Without PRBS_CHK_SAT_EN, CNT_W counters wrap modulo 2^CNT_W.
//  - Simultaneous window end and ERR_THR reached: loss of lock wins.
//  - i_enable dropping mid-acquisition freezes state; resuming continues from the frozen state.
//  - rst assertion at any time returns to reset values immediately.
// CONFIGURATION
//  PRBS_CHK_SAT_EN defined: o_bit_count and o_err_count saturate at 2^CNT_W-1.
//    Once o_bit_count saturates, both counters freeze so the ratio stays consistent.
//  PRBS_CHK_SAT_EN undefined: both counters wrap independently; no saturation logic is built.
// TESTING
//  T1 Clean PRBS9 from generator, valid every 4 clk ->
//     o_locked=1 after 9+LOCK_CNT=25 samples; o_err never 1; o_err_count=0; o_bit_count=samples since lock.
//  T2 Locked, invert one bit every 50 samples ->
//     one o_err pulse per flip, o_err_count increments by 1 each; no o_lock_lost (max 3 per 128 < 16).
//  T3 Locked, then feed constant 0 ->
//     o_lock_lost pulses once ~32 samples later (ERR_THR reached); o_locked=0; FSM held in SEED (all-zero);
//     restore PRBS -> relock in 25 samples, counters continue from prior values.
//  T4 Bit error at sample 5 of VERIFY -> return to SEED; lock only after a fresh 9+16 clean samples.
//  T5 i_enable=0 for 100 cycles mid-VERIFY with i_valid toggling -> no state/count change; resume completes lock.
//  T6 CNT_W=4, PRBS_CHK_SAT_EN defined, locked clean stream -> o_bit_count stops at 15.
//     Undefined -> o_bit_count wraps 15->0.

Source files
------------

// File: rtl/prbs9_sync_checker.sv
// prbs9_sync_checker: receive-side PRBS9 (x^9 + x^5 + 1) checker.
// Seeds a 9-bit shift register from the incoming bits. It then verifies
// LOCK_CNT consecutive predictions before it declares lock.
// While locked, the register free-runs so that line errors do not propagate.
// Loss of lock is declared when ERR_THR errors occur inside one WIN_LEN-sample window.
// Optional build macro: PRBS_CHK_SAT_EN makes the statistics counters
// saturate, and freeze together once the bit counter saturates.
module prbs9_sync_checker #(
  parameter int CNT_W    = 32,
  parameter int LOCK_CNT = 16,
  parameter int WIN_LEN  = 128,
  parameter int ERR_THR  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic             i_bit,
  output logic             o_locked,
  output logic             o_err,
  output logic             o_lock_lost,
  output logic [CNT_W-1:0] o_bit_count,
  output logic [CNT_W-1:0] o_err_count
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WIN_LEN + 1);
  localparam int WERR_W  = $clog2(ERR_THR + 1);

  typedef enum logic [1:0] {SEED, VERIFY, LOCK} state_t;

  state_t             state, state_next;
  logic [8:0]         sreg, sreg_next;
  logic [3:0]         fill, fill_next;
  logic [MATCH_W-1:0] match_cnt, match_next;
  logic [WIN_W-1:0]   win_cnt, win_next;
  logic [WERR_W-1:0]  win_err, win_err_next;
  logic [CNT_W-1:0]   bit_cnt, bit_next;
  logic [CNT_W-1:0]   err_cnt, err_next;
  logic               err_pulse_next, lost_next;
  logic               sample, pred, mismatch;
  logic [8:0]         sreg_rx;

  assign sample   = i_enable & i_valid;
  assign pred     = sreg[8] ^ sreg[4];
  assign mismatch = i_bit ^ pred;
  assign sreg_rx  = {sreg[7:0], i_bit};

  // Next-state logic: only a qualified sample advances the FSM, the register and the counters
  always_comb begin
    state_next     = state;
    sreg_next      = sreg;
    fill_next      = fill;
    match_next     = match_cnt;
    win_next       = win_cnt;
    win_err_next   = win_err;
    bit_next       = bit_cnt;
    err_next       = err_cnt;
    err_pulse_next = 1'b0;
    lost_next      = 1'b0;
    if (sample) begin
      case (state)
        SEED: begin
          sreg_next = sreg_rx;
          if (fill == 4'd8) begin
            fill_next = 4'd0;
            if (sreg_rx != 9'd0) begin
              state_next = VERIFY;
              match_next = '0;
            end
          end else begin
            fill_next = fill + 4'd1;
          end
        end
        VERIFY: begin
          sreg_next = sreg_rx;
          if (mismatch) begin
            state_next = SEED;
            fill_next  = 4'd0;
          end else begin
            match_next = match_cnt + 1'b1;
            if (match_next == MATCH_W'(LOCK_CNT)) begin
              state_next   = LOCK;
              win_next     = '0;
              win_err_next = '0;
            end
          end
        end
        LOCK: begin
          sreg_next      = {sreg[7:0], pred};
          err_pulse_next = mismatch;
`ifdef PRBS_CHK_SAT_EN
          if (!(&bit_cnt)) begin
            bit_next = bit_cnt + 1'b1;
            if (mismatch) err_next = err_cnt + 1'b1;
          end
`else
          bit_next = bit_cnt + 1'b1;
          if (mismatch) err_next = err_cnt + 1'b1;
`endif
          win_next     = win_cnt + 1'b1;
          win_err_next = win_err + WERR_W'(mismatch);
          if (win_err_next == WERR_W'(ERR_THR)) begin
            lost_next    = 1'b1;
            state_next   = SEED;
            fill_next    = 4'd0;
            win_next     = '0;
            win_err_next = '0;
          end else if (win_next == WIN_W'(WIN_LEN)) begin
            win_next     = '0;
            win_err_next = '0;
          end
        end
        default: begin
          state_next = SEED;
          fill_next  = 4'd0;
        end
      endcase
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SEED;
      sreg        <= '0;
      fill        <= '0;
      match_cnt   <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      bit_cnt     <= '0;
      err_cnt     <= '0;
      o_err       <= 1'b0;
      o_lock_lost <= 1'b0;
    end else begin
      state       <= state_next;
      sreg        <= sreg_next;
      fill        <= fill_next;
      match_cnt   <= match_next;
      win_cnt     <= win_next;
      win_err     <= win_err_next;
      bit_cnt     <= bit_next;
      err_cnt     <= err_next;
      o_err       <= err_pulse_next;
      o_lock_lost <= lost_next;
    end
  end

  assign o_locked    = (state == LOCK);
  assign o_bit_count = bit_cnt;
  assign o_err_count = err_cnt;

endmodule
